olimp_vec_dot_acc: RTL and testbench

- Parametrised successor of the fixed VEC-8U8-16I8-2S32 unit.
- Computes LANES parallel dot products of one shared int8/uint8 data vector against per-lane int8 coefficient vectors.
- Accumulates each lane's dot product across a multi-beat packet (first/last framing) with signed saturation.
- Uses valid/ready handshakes on input and output with full-pipeline backpressure.
- Sits between the operand streamer and the result writeback in the OLIMP DSP datapath.

---
 rtl/olimp_pkg.sv | 40 ++++
 rtl/olimp_mul8x8_pipe.sv | 45 ++++
 rtl/olimp_vec_dot_acc.sv | 157 +++++++++++++++
 tb/tb_olimp_vec_dot_acc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/olimp_pkg.sv
// Shared constants and arithmetic helpers for the OLIMP vector dot-product unit.
package olimp_pkg;

    localparam int ELEM_W = 8;   // data / coefficient element width
    localparam int PROD_W = 16;  // exact signed width of one ext(u8|s8) * s8 product

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Signed add of two sign-extended operands, clamped to a signed range of
    // 'width' bits (width <= 63). Result: {overflow_flag, clamped_value[63:0]},
    // where the value is sign-extended to 64 bits.
    function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int                 width);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        logic        [64:0] r;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (width - 1));
        if (s > hi) begin
            r = {1'b1, hi[63:0]};
        end else if (s < lo) begin
            r = {1'b1, lo[63:0]};
        end else begin
            r = {1'b0, s[63:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/olimp_mul8x8_pipe.sv
// One element multiplier: ext(a) * b with MUL_LAT register stages. The
// registered 8x8 form is the shape iCE40 flows pack into SB_MAC16 8x8 mode.
module olimp_mul8x8_pipe
    import olimp_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic                     clk_dsp,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     a_signed,
    input  logic [ELEM_W-1:0]        a,
    input  logic [ELEM_W-1:0]        b,
    output logic signed [PROD_W-1:0] p
);

    logic signed [PROD_W-1:0] ea;
    logic signed [PROD_W-1:0] eb;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] stg [MUL_LAT];

    // Extend a as int8 or uint8, b always int8; a 16-bit product is exact for both.
    always_comb begin
        ea   = {{(PROD_W-ELEM_W){a_signed & a[ELEM_W-1]}}, a};
        eb   = {{(PROD_W-ELEM_W){b[ELEM_W-1]}}, b};
        prod = ea * eb;
    end

    // Product pipeline; every stage holds while ce is low.
    always_ff @(posedge clk_dsp or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                stg[k] <= '0;
            end
        end else if (ce) begin
            stg[0] <= prod;
            for (int k = 1; k < MUL_LAT; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    assign p = stg[MUL_LAT-1];

endmodule

// File: rtl/olimp_vec_dot_acc.sv
// LANES parallel int8 dot products of a shared data vector, accumulated with
// signed saturation across first/last framed packets.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; a
// result transfers where out_valid && out_ready. in_ready is the global pipeline
// enable: it is low only while a result waits unconsumed, and then every stage
// holds, so nothing is dropped or duplicated. out_valid never depends on
// out_ready combinationally.
module olimp_vec_dot_acc
    import olimp_pkg::*;
#(
    parameter int N_ELEM  = 8,   // power of 2, >= 2
    parameter int LANES   = 2,
    parameter int ACC_W   = 32,  // >= 16+clog2(N_ELEM)+1 and <= 63
    parameter int MUL_LAT = 3    // >= 1
) (
    input  logic                            clk_dsp,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic                            a_signed,
    input  logic [ELEM_W*N_ELEM-1:0]        data,
    input  logic [ELEM_W*N_ELEM*LANES-1:0]  coef,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_W*LANES-1:0]          acc,
    output logic [LANES-1:0]                sat
);

    localparam int SUM_W = PROD_W + clog2(N_ELEM);

    logic ce;
    assign ce       = !(out_valid && !out_ready);
    assign in_ready = ce;

    // ---------------- stages M1..M_MUL_LAT ----------------
    logic signed [PROD_W-1:0] prod [LANES][N_ELEM];
    logic [MUL_LAT-1:0] m_valid;
    logic [MUL_LAT-1:0] m_first;
    logic [MUL_LAT-1:0] m_last;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 0; i < N_ELEM; i++) begin : g_elem
            olimp_mul8x8_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
                .clk_dsp  (clk_dsp),
                .rst_n    (rst_n),
                .ce       (ce),
                .a_signed (a_signed),
                .a        (data[ELEM_W*i +: ELEM_W]),
                .b        (coef[ELEM_W*(l*N_ELEM+i) +: ELEM_W]),
                .p        (prod[l][i])
            );
        end
    end

    // Beat framing travels alongside the products.
    always_ff @(posedge clk_dsp or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= '0;
            m_first <= '0;
            m_last  <= '0;
        end else if (ce) begin
            m_valid[0] <= in_valid;
            m_first[0] <= in_first;
            m_last[0]  <= in_last;
            for (int k = 1; k < MUL_LAT; k++) begin
                m_valid[k] <= m_valid[k-1];
                m_first[k] <= m_first[k-1];
                m_last[k]  <= m_last[k-1];
            end
        end
    end

    // ---------------- stage T: per-lane product sum ----------------
    logic signed [SUM_W-1:0] sum_c [LANES];
    logic signed [SUM_W-1:0] t_sum [LANES];
    logic                    t_valid;
    logic                    t_first;
    logic                    t_last;

    // Exact signed sum of the lane's products.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum_c[l] = '0;
            for (int i = 0; i < N_ELEM; i++) begin
                sum_c[l] = sum_c[l] + SUM_W'(prod[l][i]);
            end
        end
    end

    // Register the lane sums with their framing.
    always_ff @(posedge clk_dsp or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            t_first <= 1'b0;
            t_last  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                t_sum[l] <= '0;
            end
        end else if (ce) begin
            t_valid <= m_valid[MUL_LAT-1];
            t_first <= m_first[MUL_LAT-1];
            t_last  <= m_last[MUL_LAT-1];
            for (int l = 0; l < LANES; l++) begin
                t_sum[l] <= sum_c[l];
            end
        end
    end

    // ---------------- stage A: saturating accumulate ----------------
    logic signed [ACC_W-1:0]        acc_int [LANES];
    logic [LANES-1:0]               flag;
    logic signed [ACC_W-1:0]        add_val [LANES];
    logic [LANES-1:0]               add_ovf;
    logic [LANES-1:0][63-ACC_W:0]   add_hi_unused;
    logic [LANES-1:0]               add_flag;

    // first restarts from zero with a clear flag; otherwise add onto acc_int.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            {add_ovf[l], add_hi_unused[l], add_val[l]} =
                sat_add(t_first ? 64'sd0 : 64'(acc_int[l]), 64'(t_sum[l]), ACC_W);
            add_flag[l] = (t_first ? 1'b0 : flag[l]) | add_ovf[l];
        end
    end

    // Accumulate beats; on last publish the result and zero the lane state.
    always_ff @(posedge clk_dsp or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            acc       <= '0;
            sat       <= '0;
            flag      <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_int[l] <= '0;
            end
        end else if (ce) begin
            out_valid <= t_valid & t_last;
            if (t_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    if (t_last) begin
                        acc[ACC_W*l +: ACC_W] <= add_val[l];
                        sat[l]                <= add_flag[l];
                        acc_int[l]            <= '0;
                        flag[l]               <= 1'b0;
                    end else begin
                        acc_int[l] <= add_val[l];
                        flag[l]    <= add_flag[l];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_olimp_vec_dot_acc.sv
// Directed bench for olimp_vec_dot_acc: default build plus an ACC_W=20 build
// sharing the same stimulus.
module tb_olimp_vec_dot_acc;

    localparam int MUL_LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         in_first;
    logic         in_last;
    logic         a_signed;
    logic [63:0]  data;
    logic [127:0] coef;
    logic         out_ready;

    logic         in_ready,   in_ready20;
    logic         out_valid,  out_valid20;
    logic [63:0]  acc;
    logic [39:0]  acc20;
    logic [1:0]   sat,        sat20;

    olimp_vec_dot_acc #(.MUL_LAT(MUL_LAT)) dut (
        .clk_dsp(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .a_signed(a_signed),
        .data(data), .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .sat(sat)
    );

    olimp_vec_dot_acc #(.ACC_W(20), .MUL_LAT(MUL_LAT)) dut20 (
        .clk_dsp(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready20),
        .in_first(in_first), .in_last(in_last), .a_signed(a_signed),
        .data(data), .coef(coef), .out_valid(out_valid20), .out_ready(out_ready),
        .acc(acc20), .sat(sat20)
    );

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic signed [63:0] lane(input int l);
        logic signed [31:0] v;
        v = acc[32*l +: 32];
        return 64'(v);
    endfunction

    function automatic logic signed [63:0] lane20(input int l);
        logic signed [19:0] v;
        v = acc20[20*l +: 20];
        return 64'(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (all elements equal) and hold it until accepted.
    task automatic drive(input logic f, input logic l, input logic s,
                         input logic [7:0] d, input logic [7:0] c0, input logic [7:0] c1);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        a_signed = s;
        data     = {8{d}};
        coef     = {{8{c1}}, {8{c0}}};
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $error("FAIL drive_timeout: in_ready observed 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Advance until out_valid is seen, bounded.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $error("FAIL %s_timeout: out_valid observed 0 expected 1", tag);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int               n;
        int               pulses;
        int               got;
        logic signed [63:0] cap0, cap1;
        logic [63:0]      e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        a_signed  = 1'b1;
        data      = '0;
        coef      = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'sd0);
        check("rst_acc", 64'(acc), 64'sd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'sd1);
        check("rst_sat", 64'(sat), 64'sd0);

        // Single beat, signed: 8*2*3 = 48, 8*2*(-3) = -48; latency MUL_LAT+2.
        drive(1'b1, 1'b1, 1'b1, 8'h02, 8'h03, 8'hFD);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(MUL_LAT + 2));
        check("single_l0", lane(0), 64'sd48);
        check("single_l1", lane(1), -64'sd48);
        check("single_sat", 64'(sat), 64'sd0);
        tick();

        // uint8 0xFF: 8*255*(-128) = -261120, 8*255*1 = 2040.
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h80, 8'h01);
        wait_out("unsigned");
        check("unsigned_l0", lane(0), -64'sd261120);
        check("unsigned_l1", lane(1), 64'sd2040);
        tick();

        // int8 0xFF: 8*(-1)*(-128) = 1024, 8*(-1)*1 = -8.
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h80, 8'h01);
        wait_out("signed");
        check("signed_l0", lane(0), 64'sd1024);
        check("signed_l1", lane(1), -64'sd8);
        tick();

        // Three-beat packet of ones: 3*8 = 24 per lane, one pulse.
        drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01);
        drive(1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01);
        drive(1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01);
        pulses = 0;
        cap0   = '0;
        cap1   = '0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) begin
                pulses++;
                cap0 = lane(0);
                cap1 = lane(1);
            end
            tick();
        end
        check("three_pulses", 64'(pulses), 64'sd1);
        check("three_l0", cap0, 64'sd24);
        check("three_l1", cap1, 64'sd24);

        // Bubbles inside a packet leave the accumulator untouched: 2*8 = 16.
        drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01);
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01);
        wait_out("bubble");
        check("bubble_l0", lane(0), 64'sd16);
        check("bubble_l1", lane(1), 64'sd16);
        tick();

        // Beat without first after a completed packet starts from zero.
        drive(1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 8'h01);
        wait_out("nofirst");
        check("nofirst_l0", lane(0), 64'sd16);
        check("nofirst_l1", lane(1), 64'sd8);
        tick();

        // 40 beats of 127*127*8 = 129032: ACC_W=20 clamps at 524287.
        for (int k = 0; k < 40; k++) begin
            drive(k == 0, k == 39, 1'b1, 8'h7F, 8'h7F, 8'h7F);
        end
        wait_out("sat40");
        check("sat40_w20_l0", lane20(0), 64'sd524287);
        check("sat40_w20_l1", lane20(1), 64'sd524287);
        check("sat40_w20_flags", 64'(sat20), 64'sd3);
        check("sat40_w32_l0", lane(0), 64'sd5161280);
        check("sat40_w32_flags", 64'(sat), 64'sd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01);
        wait_out("after_sat");
        check("after_sat_w20_l0", lane20(0), 64'sd8);
        check("after_sat_w20_flags", 64'(sat20), 64'sd0);
        tick();

        // Backpressure: four single-beat packets with out_ready held low.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 1'b1, 8'(k), 8'h01, 8'h02);
            exp_q.push_back({32'(16 * k), 32'(8 * k)});
        end
        repeat (3) tick();
        check("bp_out_valid", 64'(out_valid), 64'sd1);
        check("bp_in_ready", 64'(in_ready), 64'sd0);
        check("bp_hold_a", 64'(acc), 64'(exp_q[0]));
        repeat (3) tick();
        check("bp_hold_b", 64'(acc), 64'(exp_q[0]));
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                got++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("bp_order", 64'(acc), 64'(e));
                end
            end
            tick();
        end
        check("bp_count", 64'(got), 64'sd4);

        // Reset mid-packet with a result pending: all state clears at once.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'h03, 8'h01, 8'h01);
        drive(1'b1, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05);
        drive(1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05);
        repeat (3) tick();
        check("pre_rst_valid", 64'(out_valid), 64'sd1);
        check("pre_rst_l0", lane(0), 64'sd24);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'sd0);
        check("mid_rst_acc", 64'(acc), 64'sd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'sd1);
        drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01);
        pulses = 0;
        cap0   = '0;
        cap1   = '0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) begin
                pulses++;
                cap0 = lane(0);
                cap1 = lane(1);
            end
            tick();
        end
        check("post_rst_pulses", 64'(pulses), 64'sd1);
        check("post_rst_l0", cap0, 64'sd8);
        check("post_rst_l1", cap1, 64'sd8);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
